note_player: RTL and testbench
==============================

# note_player

Sequenced playback reader for the synthesizer's recorded-performance memory. Walks the recording RAM cell by cell; each cell holds a key pattern and a hold duration in clock cycles. Drives each pattern onto `playback_keys` for its duration, then advances. Sits between the recording RAMs (key RAM and cycle-count RAM, synchronous read) and the tone generators, as the read-side counterpart of the recorder's write path.

## Interface
- `DEPTH`, 30, number of valid cells; last cell is `DEPTH-1`
- `ADDR_W`, 5, RAM address width; `DEPTH <= 2**ADDR_W`
- `KEY_W`, 4, key pattern width
- `DUR_W`, 26, duration width in clock cycles
- `clock`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  reset, synchronous, active-low
- `start`  in  1  level; sampled in IDLE only; begins playback at cell 0
- `stop`  in  1  level; aborts playback from any non-IDLE state
- `pause`  in  1  level; freezes the duration countdown while high
- `loop_en`  in  1  level; when high at end of sequence, restart at cell 0
- `rd_addr`  out  ADDR_W  RAM address (registered)
- `rd_keys`  in  KEY_W  key RAM q; valid the cycle after `rd_addr` is presented
- `rd_dur`  in  DUR_W  cycle-count RAM q; same timing as `rd_keys`
- `playback_keys`  out  KEY_W  registered key pattern to tone generators
- `playing`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle pulse on natural completion

## Operation
- States: IDLE, READ, LOAD, HOLD.
- IDLE: if `start` and not `stop`: `rd_addr<=0`, go READ. Otherwise hold.
- READ: `rd_addr` stable one cycle so the RAM registers it; go LOAD.
- LOAD: RAM data valid.
  - If `rd_dur==0` (terminator): end of sequence.
  - Else `playback_keys<=rd_keys`, `count<=rd_dur`, go HOLD.
- HOLD, `pause` high: count, address and keys frozen.
- HOLD, `pause` low:
  - `count!=1`: `count<=count-1`.
  - `count==1` and `rd_addr!=DEPTH-1`: `rd_addr<=rd_addr+1`, go READ.
  - `count==1` and `rd_addr==DEPTH-1`: end of sequence.
- End of sequence:
  - `loop_en` high and not a terminator at cell 0: `rd_addr<=0`, go READ; `playback_keys` keeps its last value; no `done`.
  - Otherwise: go IDLE, `playback_keys<=0`, `done<=1` for one cycle.
  - A terminator at cell 0 always ends, regardless of `loop_en`; this prevents an empty infinite loop.
- `stop` high in READ/LOAD/HOLD: go IDLE, `playback_keys<=0`, `rd_addr<=0`, no `done`. `stop` has priority over every other transition, including `pause` and end of sequence.
- `start` outside IDLE: ignored. `start` and `stop` both high in IDLE: stay IDLE.
- `pause` in READ or LOAD: ignored; it takes effect from HOLD.
- `rd_addr` never exceeds `DEPTH-1`. Duration arithmetic is unsigned DUR_W; there is no wrap, because the countdown stops at 1.

## Timing
- Reset values: state IDLE, `rd_addr=0`, `playback_keys=0`, `count=0`, `done=0`, `playing=0`. Reset overrides everything, including mid-HOLD.
- `playing` is decoded from the state register; it rises the cycle after the `start` edge and falls the cycle after the ending edge.
- First-note latency: `start` sampled at edge E0 → READ at E0, LOAD at E1, `playback_keys` valid after E2.
- Each note with duration d (no pause) is visible for d+2 cycles: d in HOLD, then 1 READ + 1 LOAD for the next fetch. The last note before a terminator is also visible for d+2 cycles. The final cell `DEPTH-1` is visible for d cycles.
- `done` asserts on the edge that enters IDLE and clears on the next edge.

## Test plan
- Single pass with terminator. RAM: cell0 = {0001, 3}, cell1 = {0100, 1}, cell2 dur 0. Assert `start` → `playback_keys` = 0001 for 5 cycles from E2, then 0100 for 3 cycles, then 0; `done` pulses once; `playing` high E0+1 .. E10.
- Full depth, DEPTH=4, all cells dur 2, keys 1,2,4,8 → after cell 3 expires: `done` pulse, keys 0; `rd_addr` max observed = 3.
- Loop. Same RAM with `loop_en=1` → after cell 3, `rd_addr` returns to 0 with no `done`; keys repeat 1,2,4,8. Drop `loop_en` during the second pass → ends after that pass with a `done` pulse.
- Pause. Cell0 = {0011, 4}; assert `pause` for 4 cycles mid-HOLD → note visible for 10 cycles. `pause` held only during READ/LOAD → no extension.
- Abort. Assert `stop` mid-HOLD → next cycle keys 0, `playing` 0, `done` 0. `start`+`stop` together in IDLE → stays IDLE. `reset` low mid-HOLD → all reset values next cycle.
- Terminator at cell 0 with `loop_en=1` → `done` pulses after E2; keys stay 0; returns to IDLE.

Source files
------------

// File: rtl/note_player.sv
// rtl/note_player.sv - sequenced playback reader for the recorded-performance RAM
module note_player #(
    parameter int DEPTH  = 30,
    parameter int ADDR_W = 5,
    parameter int KEY_W  = 4,
    parameter int DUR_W  = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_pause,
    input  logic              i_loop_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [KEY_W-1:0]  i_rd_keys,
    input  logic [DUR_W-1:0]  i_rd_dur,
    output logic [KEY_W-1:0]  o_playback_keys,
    output logic              o_playing,
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_LOAD = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [KEY_W-1:0]  r_keys;
    logic [DUR_W-1:0]  r_count;
    logic              r_done;

    state_t            w_next_state;
    logic [ADDR_W-1:0] w_next_addr;
    logic [KEY_W-1:0]  w_next_keys;
    logic [DUR_W-1:0]  w_next_count;
    logic              w_next_done;
    logic              w_seq_end;
    logic              w_terminator;
    logic              w_abort;

    // State and datapath registers; reset wins over every transition
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_rd_addr <= '0;
            r_keys    <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_rd_addr <= w_next_addr;
            r_keys    <= w_next_keys;
            r_count   <= w_next_count;
            r_done    <= w_next_done;
        end
    end

    // Next-state and next-datapath decode; stop is checked first in every active state
    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_rd_addr;
        w_next_keys  = r_keys;
        w_next_count = r_count;
        w_next_done  = 1'b0;
        w_seq_end    = 1'b0;
        w_terminator = 1'b0;
        w_abort      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    w_next_addr  = '0;
                    w_next_state = ST_READ;
                end
            end

            ST_READ: begin
                // Address held one cycle so the RAM can register it
                if (i_stop) begin
                    w_abort = 1'b1;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (i_stop) begin
                    w_abort = 1'b1;
                end else if (i_rd_dur == '0) begin
                    w_terminator = 1'b1;
                    w_seq_end    = 1'b1;
                end else begin
                    w_next_keys  = i_rd_keys;
                    w_next_count = i_rd_dur;
                    w_next_state = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (i_stop) begin
                    w_abort = 1'b1;
                end else if (i_pause) begin
                    // Everything frozen while paused
                    w_next_state = ST_HOLD;
                end else if (r_count != DUR_ONE) begin
                    w_next_count = r_count - DUR_ONE;
                end else if (r_rd_addr != LAST_ADDR) begin
                    w_next_addr  = r_rd_addr + ADDR_W'(1);
                    w_next_state = ST_READ;
                end else begin
                    w_seq_end = 1'b1;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // A terminator in cell 0 never loops, otherwise an empty recording would spin forever
        if (w_seq_end) begin
            if (i_loop_en && !(w_terminator && (r_rd_addr == '0))) begin
                w_next_addr  = '0;
                w_next_state = ST_READ;
            end else begin
                w_next_state = ST_IDLE;
                w_next_keys  = '0;
                w_next_done  = 1'b1;
            end
        end

        if (w_abort) begin
            w_next_state = ST_IDLE;
            w_next_keys  = '0;
            w_next_addr  = '0;
            w_next_done  = 1'b0;
        end
    end

    assign o_rd_addr       = r_rd_addr;
    assign o_playback_keys = r_keys;
    assign o_playing       = (r_state != ST_IDLE);
    assign o_done          = r_done;

endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - directed self-checking bench for note_player
module tb_note_player;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int KEY_W  = 4;
    localparam int DUR_W  = 26;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              pause = 1'b0;
    logic              loop_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic [KEY_W-1:0]  rd_keys = '0;
    logic [DUR_W-1:0]  rd_dur = '0;
    logic [KEY_W-1:0]  keys;
    logic              playing;
    logic              done;

    logic [KEY_W-1:0]  mem_keys [0:31];
    logic [DUR_W-1:0]  mem_dur  [0:31];

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [3:0] SINGLE_K [12] = '{0,0,1,1,1,1,1,4,4,4,0,0};
    localparam logic [3:0] FULL_K   [18] = '{0,0,1,1,1,1,2,2,2,2,4,4,4,4,8,8,0,0};
    localparam logic [3:0] LOOP_K   [34] = '{0,0,1,1,1,1,2,2,2,2,4,4,4,4,8,8,8,8,
                                             1,1,1,1,2,2,2,2,4,4,4,4,8,8,0,0};

    note_player #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .KEY_W (KEY_W),
        .DUR_W (DUR_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .i_start        (start),
        .i_stop         (stop),
        .i_pause        (pause),
        .i_loop_en      (loop_en),
        .o_rd_addr      (rd_addr),
        .i_rd_keys      (rd_keys),
        .i_rd_dur       (rd_dur),
        .o_playback_keys(keys),
        .o_playing      (playing),
        .o_done         (done)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM model
    always @(posedge clock) begin
        rd_keys <= mem_keys[rd_addr];
        rd_dur  <= mem_dur[rd_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 32; i++) begin
            mem_keys[i] = '0;
            mem_dur[i]  = '0;
        end
    endtask

    task automatic load_single();
        clear_ram();
        mem_keys[0] = 4'b0001; mem_dur[0] = 26'd3;
        mem_keys[1] = 4'b0100; mem_dur[1] = 26'd1;
    endtask

    task automatic load_full();
        clear_ram();
        for (int i = 0; i < 4; i++) begin
            mem_keys[i] = 4'(1 << i);
            mem_dur[i]  = 26'd2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", rd_addr); end
        n_cmp++; if (keys !== 4'd0) begin n_fail++; $display("FAIL reset_keys: got %0h expected 0", keys); end
        n_cmp++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing: got %0b expected 0", playing); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_pass();
        load_single();
        pulse_start();
        for (int n = 0; n < 12; n++) begin
            n_cmp++; if (keys !== SINGLE_K[n]) begin n_fail++; $display("FAIL single_keys[%0d]: got %0h expected %0h", n, keys, SINGLE_K[n]); end
            n_cmp++; if (playing !== (n < 10)) begin n_fail++; $display("FAIL single_playing[%0d]: got %0b expected %0b", n, playing, n < 10); end
            n_cmp++; if (done !== (n == 10)) begin n_fail++; $display("FAIL single_done[%0d]: got %0b expected %0b", n, done, n == 10); end
            tick();
        end
    endtask

    task automatic test_full_depth();
        int max_addr;
        max_addr = 0;
        load_full();
        loop_en = 1'b0;
        pulse_start();
        for (int n = 0; n < 18; n++) begin
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            n_cmp++; if (keys !== FULL_K[n]) begin n_fail++; $display("FAIL full_keys[%0d]: got %0h expected %0h", n, keys, FULL_K[n]); end
            n_cmp++; if (done !== (n == 16)) begin n_fail++; $display("FAIL full_done[%0d]: got %0b expected %0b", n, done, n == 16); end
            n_cmp++; if (playing !== (n < 16)) begin n_fail++; $display("FAIL full_playing[%0d]: got %0b expected %0b", n, playing, n < 16); end
            tick();
        end
        n_cmp++; if (max_addr != 3) begin n_fail++; $display("FAIL full_max_addr: got %0d expected 3", max_addr); end
    endtask

    task automatic test_loop();
        load_full();
        loop_en = 1'b1;
        pulse_start();
        for (int n = 0; n < 34; n++) begin
            n_cmp++; if (keys !== LOOP_K[n]) begin n_fail++; $display("FAIL loop_keys[%0d]: got %0h expected %0h", n, keys, LOOP_K[n]); end
            n_cmp++; if (done !== (n == 32)) begin n_fail++; $display("FAIL loop_done[%0d]: got %0b expected %0b", n, done, n == 32); end
            if (n == 16) begin
                n_cmp++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL loop_addr_wrap: got %0d expected 0", rd_addr); end
            end
            if (n == 20) loop_en = 1'b0;
            tick();
        end
    endtask

    task automatic test_pause();
        int cnt;
        clear_ram();
        mem_keys[0] = 4'b0011; mem_dur[0] = 26'd4;
        // Pause for four edges in the middle of HOLD
        cnt = 0;
        pulse_start();
        for (int n = 0; n < 14; n++) begin
            if (keys == 4'b0011) cnt++;
            n_cmp++; if (done !== (n == 12)) begin n_fail++; $display("FAIL pause_done[%0d]: got %0b expected %0b", n, done, n == 12); end
            if (n == 3) pause = 1'b1;
            if (n == 7) pause = 1'b0;
            tick();
        end
        n_cmp++; if (cnt != 10) begin n_fail++; $display("FAIL pause_visible: got %0d expected 10", cnt); end
        // Pause only over the READ and LOAD edges: no extension
        cnt = 0;
        pulse_start();
        for (int n = 0; n < 10; n++) begin
            if (keys == 4'b0011) cnt++;
            n_cmp++; if (done !== (n == 8)) begin n_fail++; $display("FAIL pause_rl_done[%0d]: got %0b expected %0b", n, done, n == 8); end
            if (n == 0) pause = 1'b1;
            if (n == 2) pause = 1'b0;
            tick();
        end
        n_cmp++; if (cnt != 6) begin n_fail++; $display("FAIL pause_rl_visible: got %0d expected 6", cnt); end
    endtask

    task automatic test_abort();
        load_single();
        pulse_start();
        for (int n = 0; n < 7; n++) tick();
        n_cmp++; if (keys !== 4'b0100 || rd_addr !== 5'd1) begin n_fail++; $display("FAIL abort_pre: got keys %0h addr %0d expected 4 1", keys, rd_addr); end
        // Stop on the edge where cell 1 would advance: stop must win
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++; if (keys !== 4'd0) begin n_fail++; $display("FAIL abort_keys: got %0h expected 0", keys); end
        n_cmp++; if (playing !== 1'b0) begin n_fail++; $display("FAIL abort_playing: got %0b expected 0", playing); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0b expected 0", done); end
        n_cmp++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL abort_addr: got %0d expected 0", rd_addr); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done_late: got %0b expected 0", done); end
        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        n_cmp++; if (playing !== 1'b0) begin n_fail++; $display("FAIL start_stop_idle: got %0b expected 0", playing); end
        tick();
        n_cmp++; if (playing !== 1'b0) begin n_fail++; $display("FAIL start_stop_idle2: got %0b expected 0", playing); end
        start = 1'b0;
        stop  = 1'b0;
        tick();
        // Reset mid-HOLD of cell 1
        pulse_start();
        for (int n = 0; n < 7; n++) tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (keys !== 4'd0) begin n_fail++; $display("FAIL midreset_keys: got %0h expected 0", keys); end
        n_cmp++; if (playing !== 1'b0) begin n_fail++; $display("FAIL midreset_playing: got %0b expected 0", playing); end
        n_cmp++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL midreset_addr: got %0d expected 0", rd_addr); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %0b expected 0", done); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_terminator_cell0();
        clear_ram();
        loop_en = 1'b1;
        pulse_start();
        for (int n = 0; n < 5; n++) begin
            n_cmp++; if (done !== (n == 2)) begin n_fail++; $display("FAIL term_done[%0d]: got %0b expected %0b", n, done, n == 2); end
            n_cmp++; if (playing !== (n < 2)) begin n_fail++; $display("FAIL term_playing[%0d]: got %0b expected %0b", n, playing, n < 2); end
            n_cmp++; if (keys !== 4'd0) begin n_fail++; $display("FAIL term_keys[%0d]: got %0h expected 0", n, keys); end
            tick();
        end
        loop_en = 1'b0;
    endtask

    initial begin
        clear_ram();
        test_reset();
        test_single_pass();
        test_full_depth();
        test_loop();
        test_pause();
        test_abort();
        test_terminator_cell0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
